// File: rtl/zest_spi_arb_if.sv
// zest_spi_arb_if: host, poll-table and SPI-master signals around the SPI arbiter
interface zest_spi_arb_if #(
  parameter int DW     = 32,
  parameter int N_POLL = 4,
  parameter int PAW    = 2
);
  logic                 host_req_valid;
  logic                 host_req_ready;
  logic [DW-1:0]        host_req_data;
  logic                 host_resp_valid;
  logic [DW-1:0]        host_resp_data;
  logic                 host_resp_err;
  logic                 poll_enable;
  logic [N_POLL*DW-1:0] poll_cmd;
  logic                 poll_we;
  logic [PAW-1:0]       poll_addr;
  logic [DW-1:0]        poll_data;
  logic [7:0]           poll_overrun;
  logic                 spi_start;
  logic [DW-1:0]        spi_tx;
  logic                 spi_busy;
  logic                 spi_done;
  logic [DW-1:0]        spi_rx;
  modport master (
    input  host_req_valid, host_req_data, poll_enable, poll_cmd, spi_busy, spi_done, spi_rx,
    output host_req_ready, host_resp_valid, host_resp_data, host_resp_err,
           poll_we, poll_addr, poll_data, poll_overrun, spi_start, spi_tx
  );
  modport slave (
    output host_req_valid, host_req_data, poll_enable, poll_cmd, spi_busy, spi_done, spi_rx,
    input  host_req_ready, host_resp_valid, host_resp_data, host_resp_err,
           poll_we, poll_addr, poll_data, poll_overrun, spi_start, spi_tx
  );
endinterface

// File: rtl/zest_spi_arb.sv
// zest_spi_arb: shares one SPI engine between host commands and a periodic register poller
module zest_spi_arb #(
  parameter int DW          = 32,
  parameter int N_POLL      = 4,
  parameter int PAW         = 2,
  parameter int POLL_PERIOD = 65536,
  parameter int TIMEOUT     = 4096
) (
  input logic            lb_clk,
  input logic            rst_n,
  zest_spi_arb_if.master bus
);
  localparam int TW = $clog2(POLL_PERIOD);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [DW-1:0] ERR_WORD = DW'(32'hDEADBEEF);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t          r_state, w_next;
  logic [TW-1:0]   r_timer;
  logic [CW-1:0]   r_tcnt;
  logic            r_pending, r_last_host, r_owner_host, r_err;
  logic [7:0]      r_overrun;
  logic [PAW-1:0]  r_idx;
  logic [DW-1:0]   r_tx, r_data;
  logic            w_tick, w_host_gnt, w_poll_gnt, w_timeout, w_resp;
  assign w_tick     = bus.poll_enable && r_timer == TW'(POLL_PERIOD - 1);
  // on contention the grant goes to whoever was not served last
  assign w_host_gnt = r_state == IDLE && bus.host_req_valid && (!r_pending || !r_last_host);
  assign w_poll_gnt = r_state == IDLE && r_pending && (!bus.host_req_valid || r_last_host);
  assign w_timeout  = r_tcnt == CW'(TIMEOUT - 1);
  assign w_resp     = r_state == RESP;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (w_host_gnt || w_poll_gnt) ? ISSUE : IDLE;
      ISSUE:   w_next = bus.spi_busy ? ISSUE : WAIT;
      WAIT:    w_next = (bus.spi_done || w_timeout) ? RESP : WAIT;
      default: w_next = IDLE;
    endcase
  end
  assign bus.host_req_ready  = rst_n && w_host_gnt;
  assign bus.spi_start       = r_state == ISSUE && !bus.spi_busy;
  assign bus.spi_tx          = r_tx;
  assign bus.host_resp_valid = w_resp && r_owner_host;
  assign bus.host_resp_data  = bus.host_resp_valid ? r_data : '0;
  assign bus.host_resp_err   = bus.host_resp_valid && r_err;
  assign bus.poll_we         = w_resp && !r_owner_host;
  assign bus.poll_addr       = bus.poll_we ? r_idx : '0;
  assign bus.poll_data       = bus.poll_we ? r_data : '0;
  assign bus.poll_overrun    = r_overrun;
  always_ff @(posedge lb_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_timer      <= '0;
      r_tcnt       <= '0;
      r_pending    <= 1'b0;
      r_last_host  <= 1'b0;
      r_owner_host <= 1'b0;
      r_err        <= 1'b0;
      r_overrun    <= '0;
      r_idx        <= '0;
      r_tx         <= '0;
      r_data       <= '0;
    end else begin
      r_state   <= w_next;
      r_timer   <= (!bus.poll_enable || w_tick) ? '0 : r_timer + 1'b1;
      // a tick landing on a poll grant re-arms pending instead of being consumed
      r_pending <= bus.poll_enable && (w_tick || (r_pending && !w_poll_gnt));
      if (w_tick && r_pending && !w_poll_gnt && r_overrun != 8'hFF)
        r_overrun <= r_overrun + 8'd1;
      if (w_host_gnt || w_poll_gnt) begin
        r_tx         <= w_host_gnt ? bus.host_req_data : bus.poll_cmd[32'(r_idx)*DW +: DW];
        r_owner_host <= w_host_gnt;
        r_last_host  <= w_host_gnt;
      end
      r_tcnt <= (r_state == WAIT) ? r_tcnt + 1'b1 : '0;
      if (r_state == WAIT && (bus.spi_done || w_timeout)) begin
        r_data <= bus.spi_done ? bus.spi_rx : ERR_WORD;
        r_err  <= !bus.spi_done;
      end
      if (bus.poll_we)
        r_idx <= (32'(r_idx) == N_POLL - 1) ? '0 : r_idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_zest_spi_arb.sv
// tb_zest_spi_arb: randomized SPI responder plus transaction scoreboard for zest_spi_arb
module tb_zest_spi_arb;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  zest_spi_arb_if #(.DW(32), .N_POLL(4), .PAW(2)) bus ();
  zest_spi_arb #(.DW(32), .N_POLL(4), .PAW(2), .POLL_PERIOD(16), .TIMEOUT(32)) dut (
    .lb_clk(clk), .rst_n(rst_n), .bus(bus.master)
  );
  typedef struct {bit host; logic [31:0] exp; bit err; int due;} txn_t;
  txn_t        q[$];
  txn_t        mt;
  bit          own_q[$];
  int          n_chk = 0, n_fail = 0, cyc = 0;
  int          lat = 0, dcnt = 0, ml;
  bit          hold = 0;
  logic [31:0] fix_rx = '0, cur_rx, cur_tx;
  int          m_idx = 0, m_pst = 0, n_hresp = 0, n_pwe = 0;
  logic [127:0] pcmd;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // SPI master stand-in and scoreboard: expectations fixed at each spi_start
  always @(negedge clk) begin
    cyc++;
    bus.spi_done = 1'b0;
    if (rst_n) begin
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) begin
          bus.spi_done = 1'b1;
          bus.spi_rx = cur_rx;
          chk("tx_stable", bus.spi_tx, cur_tx);
        end
      end
      if (bus.spi_start) begin
        cur_tx = bus.spi_tx;
        mt.host = cur_tx[31];
        own_q.push_back(mt.host);
        if (!mt.host) begin
          chk("poll_tx", cur_tx, pcmd[m_pst*32 +: 32]);
          m_pst = (m_pst + 1) % 4;
        end
        cur_rx = (fix_rx != 0) ? fix_rx : $urandom;
        ml = (lat != 0) ? lat : $urandom_range(1, 12);
        mt.err = hold;
        mt.exp = hold ? 32'hDEADBEEF : cur_rx;
        mt.due = cyc + (hold ? 33 : ml + 1);
        dcnt = hold ? 0 : ml;
        q.push_back(mt);
      end
      if (bus.host_resp_valid || bus.poll_we) begin
        chk("resp_excl", bus.host_resp_valid & bus.poll_we, 0);
        chk("q_depth", q.size(), 1);
        if (q.size() > 0) begin
          mt = q.pop_front();
          chk("resp_owner", bus.host_resp_valid, mt.host);
          chk("resp_data", bus.host_resp_valid ? bus.host_resp_data : bus.poll_data, mt.exp);
          chk("resp_err", bus.host_resp_err, mt.host & mt.err);
          chk("resp_cycle", cyc, mt.due);
          if (bus.poll_we) begin
            chk("poll_addr", bus.poll_addr, m_idx);
            m_idx = (m_idx + 1) % 4;
            n_pwe++;
          end else n_hresp++;
        end
      end
    end
  end
  task automatic host_txn(input logic [31:0] d);
    int t = 0;
    bus.host_req_valid = 1'b1;
    bus.host_req_data = d;
    #1;
    while (!bus.host_req_ready && t < 300) begin
      @(negedge clk); #1; t++;
    end
    chk("host_accept", bus.host_req_ready, 1);
    @(negedge clk);
    bus.host_req_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int t = 0;
    repeat (2) @(negedge clk);
    #1;
    while (q.size() != 0 && t < 400) begin
      @(negedge clk); #1; t++;
    end
    chk("drain", q.size(), 0);
    @(negedge clk);
  endtask
  task automatic clear_model();
    q.delete();
    dcnt = 0; m_idx = 0; m_pst = 0; hold = 0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int t, f, np, pend, ovr, free;
    bit tick, gnt;
    rst_n = 1'b0;
    bus.host_req_valid = 1'b1;
    bus.host_req_data = 32'h8000_0001;
    bus.poll_enable = 1'b0;
    bus.spi_busy = 1'b0;
    for (int i = 0; i < 4; i++) pcmd[i*32 +: 32] = {1'b0, 31'($urandom)};
    bus.poll_cmd = pcmd;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.host_req_ready, 0);
    chk("rst_start", bus.spi_start, 0);
    chk("rst_tx", bus.spi_tx, 0);
    chk("rst_hvalid", bus.host_resp_valid, 0);
    chk("rst_hdata", bus.host_resp_data, 0);
    chk("rst_herr", bus.host_resp_err, 0);
    chk("rst_pwe", bus.poll_we, 0);
    chk("rst_paddr", bus.poll_addr, 0);
    chk("rst_pdata", bus.poll_data, 0);
    chk("rst_ovr", bus.poll_overrun, 0);
    bus.host_req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    fix_rx = 32'h1234_5678;
    lat = 5;
    host_txn(32'h8000_00A5);
    chk("start_T1", bus.spi_start, 1);
    repeat (8) @(negedge clk);
    chk("host_resp_once", n_hresp, 1);
    fix_rx = '0;
    lat = 0;
    bus.spi_busy = 1'b1;
    host_txn({1'b1, 31'($urandom)});
    chk("busy_holds_start", bus.spi_start, 0);
    repeat (3) @(negedge clk);
    chk("busy_holds_start2", bus.spi_start, 0);
    @(posedge clk); #1;
    bus.spi_busy = 1'b0;
    @(negedge clk);
    chk("start_after_busy", bus.spi_start, 1);
    wait_idle();
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      host_txn({1'b1, 31'($urandom)});
    end
    wait_idle();
    chk("host_resp_count", n_hresp, 8);
    hold = 1;
    host_txn({1'b1, 31'($urandom)});
    wait_idle();
    hold = 0;
    host_txn({1'b1, 31'($urandom)});
    wait_idle();
    chk("after_timeout", n_hresp, 10);
    bus.poll_enable = 1'b1;
    t = 0;
    while (n_pwe < 5 && t < 1000) begin
      @(negedge clk); #1; t++;
    end
    bus.poll_enable = 1'b0;
    chk("poll_seen5", n_pwe, 5);
    wait_idle();
    repeat (40) @(negedge clk);
    chk("no_poll_disabled", n_pwe, 5);
    lat = 20;
    own_q.delete();
    bus.poll_enable = 1'b1;
    for (int i = 0; i < 11; i++) host_txn({1'b1, 31'($urandom)});
    bus.poll_enable = 1'b0;
    wait_idle();
    lat = 0;
    f = -1;
    np = 0;
    for (int i = 0; i < own_q.size(); i++) begin
      if (!own_q[i]) np++;
      if (f < 0 && !own_q[i]) f = i;
    end
    chk("poll_not_starved", np >= 5, 1);
    if (f >= 0)
      for (int i = f + 1; i < own_q.size(); i++) chk("alternate", own_q[i], !own_q[i-1]);
    rst_n = 1'b0;
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ovr_after_rst", bus.poll_overrun, 0);
    hold = 1;
    pend = 0; ovr = 0; free = 0;
    bus.poll_enable = 1'b1;
    for (int k = 0; k < 10000; k++) begin
      tick = (k % 16) == 15;
      gnt = (k >= free) && (pend != 0);
      if (tick && pend != 0 && !gnt && ovr < 255) ovr++;
      if (gnt) free = k + 35;
      pend = (tick || (pend != 0 && !gnt)) ? 1 : 0;
      @(negedge clk);
      if (k % 500 == 499) chk("overrun", bus.poll_overrun, ovr);
    end
    chk("overrun_sat", bus.poll_overrun, 255);
    bus.poll_enable = 1'b0;
    wait_idle();
    host_txn({1'b1, 31'($urandom)});
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_start", bus.spi_start, 0);
    chk("arst_tx", bus.spi_tx, 0);
    chk("arst_hvalid", bus.host_resp_valid, 0);
    chk("arst_pwe", bus.poll_we, 0);
    chk("arst_ovr", bus.poll_overrun, 0);
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    host_txn({1'b1, 31'($urandom)});
    wait_idle();
    t = 0;
    np = n_pwe;
    bus.poll_enable = 1'b1;
    while (n_pwe == np && t < 200) begin
      @(negedge clk); #1; t++;
    end
    bus.poll_enable = 1'b0;
    chk("poll_after_rst", n_pwe, np + 1);
    wait_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
